// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage.
// Holds the project data/oprn/tag widths, the ALU operation codes, the issue
// FSM state encoding and a helper that classifies an oprn as legal.
package alu_issue_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OPRN_W = 6;
  localparam int ALU_TAG_W  = 5;

  localparam logic [ALU_OPRN_W-1:0] OP_ADD = 6'h01;
  localparam logic [ALU_OPRN_W-1:0] OP_SUB = 6'h02;
  localparam logic [ALU_OPRN_W-1:0] OP_MUL = 6'h03;
  localparam logic [ALU_OPRN_W-1:0] OP_SRL = 6'h04;
  localparam logic [ALU_OPRN_W-1:0] OP_SLL = 6'h05;
  localparam logic [ALU_OPRN_W-1:0] OP_AND = 6'h06;
  localparam logic [ALU_OPRN_W-1:0] OP_OR  = 6'h07;
  localparam logic [ALU_OPRN_W-1:0] OP_NOR = 6'h08;
  localparam logic [ALU_OPRN_W-1:0] OP_SLT = 6'h09;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  function automatic logic oprn_legal(input logic [ALU_OPRN_W-1:0] oprn);
    return (oprn >= OP_ADD) && (oprn <= OP_SLT);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the issue stage's three sides: request handshake (producer),
// registered ALU drive / combinational ALU return, and result handshake
// (consumer), plus FIFO occupancy.
//   slave  : the issue stage's view
//   master : the surrounding datapath / ALU / consumer view
interface alu_issue_if
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_W,
  parameter int OPRN_WIDTH = ALU_OPRN_W,
  parameter int TAG_WIDTH  = ALU_TAG_W,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_op1;
  logic [DATA_WIDTH-1:0] req_op2;
  logic [OPRN_WIDTH-1:0] req_oprn;
  logic [TAG_WIDTH-1:0]  req_tag;

  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [OPRN_WIDTH-1:0] alu_oprn;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_zero;

  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_zero;
  logic                  res_err;
  logic [TAG_WIDTH-1:0]  res_tag;

  logic [CNT_W-1:0]      occupancy;

  modport slave (
    input  req_valid, req_op1, req_op2, req_oprn, req_tag,
    input  alu_out, alu_zero, res_ready,
    output req_ready, alu_op1, alu_op2, alu_oprn,
    output res_valid, res_data, res_zero, res_err, res_tag, occupancy
  );

  modport master (
    output req_valid, req_op1, req_op2, req_oprn, req_tag,
    output alu_out, alu_zero, res_ready,
    input  req_ready, alu_op1, alu_op2, alu_oprn,
    input  res_valid, res_data, res_zero, res_err, res_tag, occupancy
  );
endinterface

// File: rtl/alu_issue_fifo.sv
// Synchronous request FIFO for the issue stage.
// Ports: clk, rst_n (async low), push/din, pop/dout (head, combinational),
// full, empty, count. Caller guarantees no push when full without a pop and
// no pop when empty. Pointers wrap naturally (DEPTH is a power of two).
module alu_issue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/alu_issue_stage.sv
// Issue / result-capture stage in front of the combinational ALU.
// Ports: clk, rst_n (async low), bus (alu_issue_if.slave): request
// handshake in, registered ALU operands out, ALU result in, result
// handshake out, FIFO occupancy.
// Requests queue in a FIFO; a 3-state FSM (IDLE/DRIVE/HOLD) loads the head
// into the ALU operand registers and captures the ALU output into a result
// register once the consumer side has room.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_W,
  parameter int OPRN_WIDTH = ALU_OPRN_W,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = ALU_TAG_W
) (
  input logic       clk,
  input logic       rst_n,
  alu_issue_if.slave bus
);
  localparam int ENTRY_W = 2*DATA_WIDTH + OPRN_WIDTH + TAG_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  state_t state, state_nx;

  logic                  push, pop, capture, capture_ok;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic [DATA_WIDTH-1:0] h_op1, h_op2;
  logic [OPRN_WIDTH-1:0] h_oprn;
  logic [TAG_WIDTH-1:0]  h_tag;

  logic [DATA_WIDTH-1:0] alu_op1_q, alu_op2_q;
  logic [OPRN_WIDTH-1:0] alu_oprn_q;
  logic [TAG_WIDTH-1:0]  inf_tag_q;
  logic                  res_valid_q, res_zero_q, res_err_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic [TAG_WIDTH-1:0]  res_tag_q;
  logic                  legal;

  // A pop frees a slot this cycle, so a full FIFO can still take a push.
  assign bus.req_ready = rst_n && (!fifo_full || pop);
  assign push          = bus.req_valid && bus.req_ready;

  alu_issue_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({bus.req_op1, bus.req_op2, bus.req_oprn, bus.req_tag}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {h_op1, h_op2, h_oprn, h_tag} = fifo_dout;

  assign capture_ok = !res_valid_q || bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = S_DRIVE;
        end
      end
      S_DRIVE, S_HOLD: begin
        if (capture_ok) begin
          capture  = 1'b1;
          pop      = !fifo_empty;
          state_nx = fifo_empty ? S_IDLE : S_DRIVE;
        end else begin
          state_nx = S_HOLD;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand registers only change on a pop, so they stay stable in HOLD/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op1_q  <= '0;
      alu_op2_q  <= '0;
      alu_oprn_q <= '0;
      inf_tag_q  <= '0;
    end else if (pop) begin
      alu_op1_q  <= h_op1;
      alu_op2_q  <= h_op2;
      alu_oprn_q <= h_oprn;
      inf_tag_q  <= h_tag;
    end
  end

  // Illegal ops ignore the ALU output entirely.
  assign legal = oprn_legal(alu_oprn_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      res_tag_q   <= '0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_data_q  <= legal ? bus.alu_out : '0;
      res_zero_q  <= legal && bus.alu_zero;
      res_err_q   <= !legal;
      res_tag_q   <= inf_tag_q;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.alu_op1   = alu_op1_q;
  assign bus.alu_op2   = alu_op2_q;
  assign bus.alu_oprn  = alu_oprn_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.occupancy = fifo_count;
endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  localparam int DW = 32, OW = 6, TW = 5, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) bus ();

  alu_issue_stage #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Golden ALU: {zero, result}. Illegal ops return junk with zero set, which
  // the stage must ignore.
  function automatic logic [DW:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [OW-1:0] op);
    logic [DW-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_SRL:  r = a >> b;
      OP_SLL:  r = a << b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return {1'b1, 32'hDEAD_BEEF};
    endcase
    return {(r == '0), r};
  endfunction

  always_comb {bus.alu_zero, bus.alu_out} = alu_f(bus.alu_op1, bus.alu_op2, bus.alu_oprn);

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [DW-1:0] op1, op2;
    logic [OW-1:0] oprn;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          zero, err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          zero;
    logic [TW-1:0] tag;
  } exp_t;

  // Single request into an idle stage with res_ready high: checks accept,
  // two-edge latency and every result field.
  task automatic run_vec(input string nm, input vec_t v);
    int n;
    bus.req_op1 = v.op1; bus.req_op2 = v.op2; bus.req_oprn = v.oprn; bus.req_tag = v.tag;
    bus.req_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready && n < 20) begin tick(); #1; n++; end
    chk({nm, " accept"}, bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 10) begin tick(); n++; end
    chk({nm, " latency"}, n, 2);
    chk({nm, " data"}, bus.res_data, v.data);
    chk({nm, " zero"}, bus.res_zero, v.zero);
    chk({nm, " err"},  bus.res_err,  v.err);
    chk({nm, " tag"},  bus.res_tag,  v.tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[13];
    vec_t v;
    exp_t expq[$];
    exp_t e;
    logic [DW-1:0] r_op1[20], r_op2[20];
    logic [OW-1:0] r_oprn[20];
    logic [DW:0]   m;
    int idx, sent, got, cyc;

    vt[0]  = '{32'd15,        32'd3,         6'h01, 5'd7,  32'd18,        1'b0, 1'b0};
    vt[1]  = '{32'd100,       32'd58,        6'h02, 5'd1,  32'd42,        1'b0, 1'b0};
    vt[2]  = '{32'd6,         32'd7,         6'h03, 5'd2,  32'd42,        1'b0, 1'b0};
    vt[3]  = '{32'h80,        32'd3,         6'h04, 5'd3,  32'd16,        1'b0, 1'b0};
    vt[4]  = '{32'd3,         32'd4,         6'h05, 5'd4,  32'd48,        1'b0, 1'b0};
    vt[5]  = '{32'hF0F0,      32'h0FF0,      6'h06, 5'd5,  32'h00F0,      1'b0, 1'b0};
    vt[6]  = '{32'hF000,      32'h000F,      6'h07, 5'd6,  32'hF00F,      1'b0, 1'b0};
    vt[7]  = '{32'hFFFF_0000, 32'h0000_FFFF, 6'h08, 5'd7,  32'd0,         1'b1, 1'b0};
    vt[8]  = '{32'd0,         32'd0,         6'h00, 5'd8,  32'd0,         1'b0, 1'b1};
    vt[9]  = '{32'd1,         32'd2,         6'h0A, 5'd9,  32'd0,         1'b0, 1'b1};
    vt[10] = '{32'd11,        32'd15,        6'h09, 5'd10, 32'd1,         1'b0, 1'b0};
    vt[11] = '{32'd15,        32'd11,        6'h09, 5'd11, 32'd0,         1'b1, 1'b0};
    vt[12] = '{32'hFFFF_FFFF, 32'd1,         6'h09, 5'd12, 32'd1,         1'b0, 1'b0};

    // Reset state; a request offered during reset must not be accepted.
    bus.req_valid = 1'b1; bus.req_op1 = 32'd1; bus.req_op2 = 32'd1;
    bus.req_oprn = OP_ADD; bus.req_tag = '0; bus.res_ready = 1'b1;
    #3;
    chk("rst req_ready", bus.req_ready, 0);
    chk("rst res_valid", bus.res_valid, 0);
    chk("rst occupancy", bus.occupancy, 0);
    chk("rst alu_op1",   bus.alu_op1, 0);
    chk("rst alu_oprn",  bus.alu_oprn, 0);
    chk("rst res_data",  bus.res_data, 0);
    bus.req_valid = 1'b0;
    #19 rst_n = 1'b1;
    tick();
    chk("post-rst occupancy", bus.occupancy, 0);

    // Table of single-request vectors.
    for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Back-to-back: 5-5 then 7*5 on consecutive cycles.
    tick();
    bus.req_op1 = 32'd5; bus.req_op2 = 32'd5; bus.req_oprn = OP_SUB; bus.req_tag = 5'd3;
    bus.req_valid = 1'b1; #1;
    chk("b2b ready0", bus.req_ready, 1);
    tick();
    bus.req_op1 = 32'd7; bus.req_op2 = 32'd5; bus.req_oprn = OP_MUL; bus.req_tag = 5'd4; #1;
    chk("b2b ready1", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    cyc = 0;
    while (!bus.res_valid && cyc < 10) begin tick(); cyc++; end
    chk("b2b first latency", cyc, 1);
    chk("b2b sub data", bus.res_data, 0);
    chk("b2b sub zero", bus.res_zero, 1);
    chk("b2b sub tag",  bus.res_tag, 3);
    tick();
    chk("b2b mul valid", bus.res_valid, 1);
    chk("b2b mul data",  bus.res_data, 35);
    chk("b2b mul zero",  bus.res_zero, 0);
    chk("b2b mul tag",   bus.res_tag, 4);
    tick();
    chk("b2b drained", bus.res_valid, 0);

    // Capacity with the consumer stalled: DEPTH+2 requests fit.
    bus.res_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      if (idx < 8) begin
        bus.req_op1 = 32'(10 + idx); bus.req_op2 = 32'd100; bus.req_oprn = OP_ADD;
        bus.req_tag = TW'(10 + idx); bus.req_valid = 1'b1;
      end
      #1;
      if (bus.req_valid && bus.req_ready) idx++;
      tick();
    end
    #1;
    chk("cap accepted",  idx, 6);
    chk("cap req_ready", bus.req_ready, 0);
    chk("cap occupancy", bus.occupancy, 4);
    chk("cap res_valid", bus.res_valid, 1);
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("drain%0d valid", k), bus.res_valid, 1);
      chk($sformatf("drain%0d tag", k),   bus.res_tag, 10 + k);
      chk($sformatf("drain%0d data", k),  bus.res_data, 110 + k);
      tick();
    end
    chk("drain empty valid", bus.res_valid, 0);
    chk("drain empty occ",   bus.occupancy, 0);

    // Reset mid-stream: 1 result, 1 held, 3 buffered.
    bus.res_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 5) begin
        bus.req_op1 = 32'd1; bus.req_op2 = 32'd1; bus.req_oprn = OP_ADD;
        bus.req_tag = TW'(20 + idx); bus.req_valid = 1'b1;
      end else bus.req_valid = 1'b0;
      #1;
      if (bus.req_valid && bus.req_ready) idx++;
      tick();
    end
    bus.req_valid = 1'b0;
    chk("mid accepted",     idx, 5);
    chk("mid occupancy",    bus.occupancy, 3);
    chk("mid res_valid",    bus.res_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst res_valid", bus.res_valid, 0);
    chk("midrst occupancy", bus.occupancy, 0);
    chk("midrst alu_op1",   bus.alu_op1, 0);
    chk("midrst alu_oprn",  bus.alu_oprn, 0);
    chk("midrst req_ready", bus.req_ready, 0);
    tick(); tick();
    #2 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    v = '{32'd1, 32'd5, 6'h05, 5'd30, 32'd32, 1'b0, 1'b0};
    run_vec("post-midrst sll", v);

    // Random legal requests with res_ready toggling every cycle.
    for (int i = 0; i < 20; i++) begin
      r_op1[i]  = $urandom_range(0, 1000);
      r_op2[i]  = $urandom_range(0, 31);
      r_oprn[i] = OW'($urandom_range(1, 9));
    end
    tick();
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 400) begin
      bus.res_ready = cyc[0];
      if (sent < 20) begin
        bus.req_op1 = r_op1[sent]; bus.req_op2 = r_op2[sent];
        bus.req_oprn = r_oprn[sent]; bus.req_tag = TW'(sent); bus.req_valid = 1'b1;
      end else bus.req_valid = 1'b0;
      #1;
      if (bus.res_valid && bus.res_ready) begin
        if (expq.size() == 0) begin
          chk("rand unexpected result", 1, 0);
        end else begin
          e = expq.pop_front();
          chk($sformatf("rand%0d data", got), bus.res_data, e.data);
          chk($sformatf("rand%0d zero", got), bus.res_zero, e.zero);
          chk($sformatf("rand%0d err", got),  bus.res_err, 0);
          chk($sformatf("rand%0d tag", got),  bus.res_tag, e.tag);
        end
        got++;
      end
      if (bus.req_valid && bus.req_ready) begin
        m = alu_f(bus.req_op1, bus.req_op2, bus.req_oprn);
        e.data = m[DW-1:0]; e.zero = m[DW]; e.tag = bus.req_tag;
        expq.push_back(e);
        sent++;
      end
      tick();
      cyc++;
    end
    bus.req_valid = 1'b0;
    chk("rand results", got, 20);
    bus.res_ready = 1'b1;
    tick(); tick(); tick();
    chk("rand no extra result", bus.res_valid, 0);
    chk("rand fifo empty",      bus.occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Sequential issue and result-capture stage that sits directly upstream of the combinational ALU. It buffers ALU requests (op1, op2, oprn, tag) arriving on a valid/ready handshake in a small FIFO. It drives registered operands into the ALU's OP1/OP2/OPRN inputs, captures the ALU's OUT/ZERO into a result register, and presents that result downstream on a second valid/ready handshake. This decouples the ALU from producer/consumer stalls in the processor datapath.

Parameters:
DATA_WIDTH, 32, operand/result width; must equal the project data width
OPRN_WIDTH, 6, ALU operation code width; must equal the project ALU oprn width
DEPTH, 4, request FIFO entries; power of two, at least 2
TAG_WIDTH, 5, opaque request tag carried unchanged to the result (e.g. destination register)

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  asynchronous active-low reset
REQ_VALID  in  1  request present
REQ_READY  out  1  stage can accept a request this cycle
REQ_OP1  in  DATA_WIDTH  operand 1
REQ_OP2  in  DATA_WIDTH  operand 2
REQ_OPRN  in  OPRN_WIDTH  ALU operation code
REQ_TAG  in  TAG_WIDTH  request tag
ALU_OP1  out  DATA_WIDTH  registered operand 1 to ALU
ALU_OP2  out  DATA_WIDTH  registered operand 2 to ALU
ALU_OPRN  out  OPRN_WIDTH  registered operation to ALU
ALU_OUT  in  DATA_WIDTH  ALU result (combinational from ALU_OP1/OP2/OPRN)
ALU_ZERO  in  1  ALU zero flag
RES_VALID  out  1  result register holds a result
RES_READY  in  1  consumer accepts the result
RES_DATA  out  DATA_WIDTH  captured result
RES_ZERO  out  1  captured zero flag
RES_ERR  out  1  request had an illegal oprn
RES_TAG  out  TAG_WIDTH  tag of the captured request
OCCUPANCY  out  clog2(DEPTH)+1  FIFO entry count

Behaviour:
- Reset (RST low, asynchronous): FIFO emptied, pointers and OCCUPANCY = 0. FSM goes to IDLE. ALU_OP1/ALU_OP2/ALU_OPRN = 0. RES_VALID = 0; RES_DATA, RES_TAG = 0; RES_ZERO, RES_ERR = 0. In-flight and buffered requests are discarded. REQ_READY = 0 while RST is low.
- Request handshake: a transfer occurs on a rising edge with REQ_VALID && REQ_READY. REQ_READY = (OCCUPANCY < DEPTH), or when a pop happens the same cycle. REQ_* are held by the producer while valid and not ready.
- FSM states IDLE, DRIVE, HOLD:
  - IDLE: if the FIFO is non-empty, pop the head into the ALU_* registers and the in-flight tag → DRIVE. ALU_* keep their last values while IDLE.
  - DRIVE: the ALU output is valid during this cycle. Capture is allowed when RES_VALID = 0 or RES_READY = 1.
    - Capture allowed: load RES_* on the edge and set RES_VALID = 1. If the FIFO is non-empty, pop the next head into ALU_* the same edge and stay in DRIVE; otherwise → IDLE.
    - Capture not allowed: → HOLD.
  - HOLD: ALU_* are held stable. Capture under the same rule and with the same next-state logic as DRIVE.
- Result handshake: RES_VALID clears on an edge with RES_READY = 1 and no new capture that edge. RES_* are stable while RES_VALID && !RES_READY.
- Latency: request accepted at edge N into an empty idle stage → ALU_* loaded at edge N+1 → RES_VALID at edge N+2. With RES_READY = 1 throughout, throughput is one result per cycle.
- Capacity with RES_READY held low: exactly DEPTH+2 requests are accepted (1 in the result register, 1 in HOLD, DEPTH in the FIFO).
- Simultaneous push and pop on a full FIFO is legal; OCCUPANCY is unchanged. Push on empty with FSM in IDLE: the entry is popped no earlier than the following edge.
- Legal oprn is 0x01..0x09. For any other value: RES_ERR = 1, RES_DATA = 0, RES_ZERO = 0, and ALU_OUT is ignored. For legal ops: RES_ERR = 0, RES_DATA = ALU_OUT, RES_ZERO = ALU_ZERO.
- Ordering: strict FIFO order; RES_TAG always matches its request.
- Pointers wrap modulo DEPTH; full/empty are derived from OCCUPANCY.

Decomposition:
- Shared project definitions header holds: data width, ALU oprn width, oprn codes 0x01..0x09, and FSM state encodings (IDLE = 0, DRIVE = 1, HOLD = 2).
- One sub-module: alu_issue_fifo (synchronous FIFO, width DATA_WIDTH*2 + OPRN_WIDTH + TAG_WIDTH, depth DEPTH, async active-low reset, push/pop/full/empty/count).
- The FSM and result register live in the top module. The bench instantiates the real ALU between ALU_* and ALU_OUT/ALU_ZERO.

Test Plan:
- Request op1 = 15, op2 = 3, oprn = 0x01, tag = 7, RES_READY = 1 → two edges later RES_VALID = 1, RES_DATA = 18, RES_ZERO = 0, RES_TAG = 7.
- Back-to-back 5−5 (0x02) then 7*5 (0x03) with RES_READY = 1 → consecutive cycles give RES_DATA 0 with RES_ZERO 1, then 35 with RES_ZERO 0.
- RES_READY = 0 with 8 requests offered at DEPTH = 4 → exactly 6 accepted, REQ_READY = 0, OCCUPANCY = 4. Then RES_READY = 1 → remaining results drain in order with correct tags, one per cycle.
- oprn = 0x00 and oprn = 0x0A → RES_ERR = 1, RES_DATA = 0, RES_ZERO = 0. A following 11 < 15 (0x09) → RES_DATA = 1, RES_ERR = 0.
- Assert RST low mid-stream with 3 entries buffered and a result pending → immediately RES_VALID = 0, OCCUPANCY = 0, ALU_* = 0. After release, a new 1 << 5 (0x05) request yields 32.
- Alternate RES_READY 1/0 each cycle over 20 random legal requests → every result matches a golden ALU model, tags are in order, and no loss or duplication occurs.
